// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
//   DATA_WIDTH / REG_ADDR_WIDTH / NUM_REGS : default geometry
//   REG_ZERO                               : hardwired-zero register index
//   req_e                                  : requester id for pointer and grant
package regfile_write_arbiter_pkg;
  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 3;
  localparam int NUM_REGS       = 8;

  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;
endpackage

// File: rtl/regfile_write_arbiter_wb_hold_buffer.sv
// One-entry writeback holding buffer.
//   in_valid/in_ready/in_reg/in_data : requester handshake
//   grant                            : entry is being issued this cycle
//   full/buf_reg/buf_data            : buffered entry
// Offers to register 0 are acknowledged but never stored.
module wb_hold_buffer #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_ADDR_WIDTH-1:0] in_reg,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      grant,
  output logic                      full,
  output logic [REG_ADDR_WIDTH-1:0] buf_reg,
  output logic [DATA_WIDTH-1:0]     buf_data
);
  logic                      full_q, full_d;
  logic [REG_ADDR_WIDTH-1:0] reg_q, reg_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      load;

  always_comb begin
    in_ready = !full_q || grant;
    load     = in_valid && in_ready && (in_reg != '0);
    full_d   = full_q;
    reg_d    = reg_q;
    data_d   = data_q;
    if (load) begin
      // A release and a reload on the same edge keeps the buffer full.
      full_d = 1'b1;
      reg_d  = in_reg;
      data_d = in_data;
    end else if (grant) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      reg_q  <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      reg_q  <= reg_d;
      data_q <= data_d;
    end
  end

  assign full     = full_q;
  assign buf_reg  = reg_q;
  assign buf_data = data_q;
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the
// ALU writeback (A) and the memory-load writeback (B).
//   a_*/b_*           : requester valid/ready handshakes with reg and data
//   write_reg/write_data/signal_reg_write : registered write port
//   pending_mask      : registers with a write buffered or being issued
//   collision_count   : saturating count of cycles with both buffers full
module regfile_write_arbiter #(
  parameter int DATA_WIDTH     = regfile_write_arbiter_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = regfile_write_arbiter_pkg::REG_ADDR_WIDTH,
  parameter int NUM_REGS       = regfile_write_arbiter_pkg::NUM_REGS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [REG_ADDR_WIDTH-1:0] a_reg,
  input  logic [DATA_WIDTH-1:0]     a_data,
  input  logic                      b_valid,
  output logic                      b_ready,
  input  logic [REG_ADDR_WIDTH-1:0] b_reg,
  input  logic [DATA_WIDTH-1:0]     b_data,
  output logic [REG_ADDR_WIDTH-1:0] write_reg,
  output logic [DATA_WIDTH-1:0]     write_data,
  output logic                      signal_reg_write,
  output logic [NUM_REGS-1:0]       pending_mask,
  output logic [7:0]                collision_count
);
  import regfile_write_arbiter_pkg::*;

  logic                      a_full, b_full;
  logic [REG_ADDR_WIDTH-1:0] a_breg, b_breg;
  logic [DATA_WIDTH-1:0]     a_bdata, b_bdata;
  logic                      grant_a, grant_b;

  req_e                      ptr_q, ptr_d;
  logic                      we_q, we_d;
  logic [REG_ADDR_WIDTH-1:0] wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [7:0]                coll_q, coll_d;

  wb_hold_buffer #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_buf_a (
    .clk(clk), .reset(reset),
    .in_valid(a_valid), .in_ready(a_ready), .in_reg(a_reg), .in_data(a_data),
    .grant(grant_a), .full(a_full), .buf_reg(a_breg), .buf_data(a_bdata)
  );

  wb_hold_buffer #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_buf_b (
    .clk(clk), .reset(reset),
    .in_valid(b_valid), .in_ready(b_ready), .in_reg(b_reg), .in_data(b_data),
    .grant(grant_b), .full(b_full), .buf_reg(b_breg), .buf_data(b_bdata)
  );

  // The pointer only moves on contended grants.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    ptr_d   = ptr_q;
    if (a_full && b_full) begin
      if (ptr_q == REQ_A) begin
        grant_a = 1'b1;
        ptr_d   = REQ_B;
      end else begin
        grant_b = 1'b1;
        ptr_d   = REQ_A;
      end
    end else begin
      grant_a = a_full;
      grant_b = b_full;
    end
  end

  always_comb begin
    we_d    = grant_a || grant_b;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (grant_a) begin
      wreg_d  = a_breg;
      wdata_d = a_bdata;
    end else if (grant_b) begin
      wreg_d  = b_breg;
      wdata_d = b_bdata;
    end
    coll_d = coll_q;
    if (a_full && b_full && (coll_q != 8'hFF)) coll_d = coll_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= REQ_A;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      coll_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      coll_q  <= coll_d;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      pending_mask[r] = (a_full && (a_breg == REG_ADDR_WIDTH'(r))) ||
                        (b_full && (b_breg == REG_ADDR_WIDTH'(r))) ||
                        (we_q   && (wreg_q == REG_ADDR_WIDTH'(r)));
    end
  end

  assign signal_reg_write = we_q;
  assign write_reg        = wreg_q;
  assign write_data       = wdata_q;
  assign collision_count  = coll_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [2:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;
  logic [2:0]  write_reg;
  logic [31:0] write_data;
  logic        signal_reg_write;
  logic [7:0]  pending_mask;
  logic [7:0]  collision_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  r;
    logic [31:0] d;
  } entry_t;

  entry_t hold_a[$];
  entry_t hold_b[$];
  entry_t exp_q[$];

  // Reference state
  bit          live = 0;
  bit          turn_b = 0;
  int          coll = 0;
  bit          exp_we = 0;
  logic [2:0]  last_reg = '0;
  logic [31:0] last_data = '0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(3), .NUM_REGS(8)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .write_reg(write_reg), .write_data(write_data),
    .signal_reg_write(signal_reg_write),
    .pending_mask(pending_mask), .collision_count(collision_count)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: evaluates each cycle from the handshake rules.
  always @(negedge clk) begin
    bit fa, fb, era, erb;
    int g;
    logic [7:0] mask;
    #1;
    fa = hold_a.size() != 0;
    fb = hold_b.size() != 0;
    g = 0;
    if (fa && fb) g = turn_b ? 2 : 1;
    else if (fa)  g = 1;
    else if (fb)  g = 2;
    era = !fa || (g == 1);
    erb = !fb || (g == 2);
    mask = '0;
    foreach (hold_a[i]) mask[hold_a[i].r] = 1'b1;
    foreach (hold_b[i]) mask[hold_b[i].r] = 1'b1;
    if (exp_we) mask[last_reg] = 1'b1;
    if (live) begin
      chk("a_ready", 32'(a_ready), 32'(era));
      chk("b_ready", 32'(b_ready), 32'(erb));
      chk("pending_mask", 32'(pending_mask), 32'(mask));
      chk("collision_count", 32'(collision_count), coll);
      chk("signal_reg_write", 32'(signal_reg_write), 32'(exp_we));
      if (!exp_we) begin
        chk("hold_write_reg", 32'(write_reg), 32'(last_reg));
        chk("hold_write_data", write_data, last_data);
      end
    end
    if (reset) begin
      hold_a.delete(); hold_b.delete(); exp_q.delete();
      turn_b = 0; coll = 0; exp_we = 0;
      last_reg = '0; last_data = '0;
      live = 1;
    end else if (live) begin
      entry_t e;
      if (fa && fb) begin
        turn_b = !turn_b;
        if (coll < 255) coll++;
      end
      exp_we = (g != 0);
      if (g == 1) e = hold_a.pop_front();
      if (g == 2) e = hold_b.pop_front();
      if (g != 0) begin
        exp_q.push_back(e);
        last_reg = e.r;
        last_data = e.d;
      end
      if (a_valid && era && a_reg != 3'd0) hold_a.push_back('{r: a_reg, d: a_data});
      if (b_valid && erb && b_reg != 3'd0) hold_b.push_back('{r: b_reg, d: b_data});
    end
  end

  // Monitor: every issued write must match the oldest expected one.
  always @(negedge clk) begin
    if (signal_reg_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual reg=%0d data=%h required=none", write_reg, write_data);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        chk("write_reg", 32'(write_reg), 32'(e.r));
        chk("write_data", write_data, e.d);
      end
    end
  end

  task automatic cyc(input bit rst, input bit av, input logic [2:0] ar, input logic [31:0] ad,
                     input bit bv, input logic [2:0] br, input logic [31:0] bd);
    reset = rst;
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    // Single uncontended write
    cyc(0, 1, 3'd3, 32'h1234_5678, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    // Both requesters every cycle
    for (int n = 0; n < 20; n++) cyc(0, 1, 3'd1, 32'hA0 + n, 1, 3'd2, 32'hB0 + n);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    // Register 0 is discarded
    cyc(0, 1, 3'd0, 32'hDEAD, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    // Same register from both sides in one cycle
    cyc(0, 1, 3'd5, 32'h11, 1, 3'd5, 32'h22);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    // Reset with both buffers full
    for (int n = 0; n < 3; n++) cyc(0, 1, 3'd6, 32'hC0 + n, 1, 3'd7, 32'hD0 + n);
    cyc(1, 1, 3'd6, 32'hEE, 1, 3'd7, 32'hFF);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    // Long contention
    for (int n = 0; n < 300; n++) cyc(0, 1, 3'd4, $urandom, 1, 3'd3, $urandom);
    chk("collision_saturated", 32'(collision_count), 32'd255);
    cyc(0, 1, 3'd4, 32'h5A, 1, 3'd3, 32'hA5);
    chk("collision_held", 32'(collision_count), 32'd255);
    // Randomized traffic, with occasional resets
    for (int n = 0; n < 500; n++) begin
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom);
    end
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
